bus_router: RTL and testbench
=============================

BUS_ROUTER -- requirements
Module: bus_router

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
- AW, 20, address width.
- DW, 8, data width.
- NREG, 4, number of decoded regions (1..8).
- BASE, {20'hFE000,20'hA0000,20'h00000,20'h00000}, packed NREG×AW region bases; region i at bits [i*AW +: AW].
- MASK, {20'hFE000,20'hFC000,20'hC0000,20'h00000}, packed NREG×AW compare masks.
- REG_EN, 4'b0111, region i decodes only if bit i is 1.
- WAIT, {4'd0,4'd1,4'd0,4'd0}, packed NREG×4 wait states per region.
- OPEN_BUS, 8'hFF, read data for unmapped accesses.
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- clock, in, 1, single clock.
- reset_n, in, 1, asynchronous active-low reset.
- cpu_req, cpu_we, in, 1 each, CPU request and write strobe.
- cpu_address, in, AW, CPU address.
- cpu_out, in, DW, CPU write data.
- cpu_in, out, DW, CPU read data.
- cpu_ready, out, 1, CPU completion pulse.
- dma_req, dma_we, dma_address, dma_out, dma_in, dma_ready: same as the cpu_* ports, for the second master.
- mem_address, out, AW, shared memory address.
- mem_d, out, DW, shared memory write data.
- mem_we, out, NREG, one-hot region write enables.
- mem_q, in, NREG×DW, packed region read data.
- unmapped, out, 1, sticky unmapped-access flag.

Function
REQ-003 Region match SHALL be (addr & MASK[i]) == (BASE[i] & MASK[i]) with REG_EN[i]=1.
REQ-004 When several regions match, the lowest index SHALL win.
REQ-005 An access matching no region SHALL be unmapped.
REQ-006 FSM states SHALL be IDLE, ACCESS and DONE; reset state IDLE.
REQ-007 Transitions out of IDLE SHALL be:
- with any req high: load the grant, latch address, data and we of the granted master, load the wait counter with WAIT[region], go to ACCESS;
- with no req: stay in IDLE.
REQ-008 ACCESS SHALL last WAIT[region]+1 cycles, counting down to 0.
REQ-009 mem_we[region] SHALL be 1 only in the first ACCESS cycle of a write.
REQ-010 mem_we SHALL never be asserted for a read or an unmapped access.
REQ-011 In the last ACCESS cycle:
- a read SHALL capture mem_q[region] (or OPEN_BUS if unmapped) into the granted master's read-data register;
- the FSM SHALL then go to DONE.
REQ-012 In DONE, the granted master's ready SHALL be 1 for exactly one cycle; the FSM SHALL return to IDLE on the next cycle.
REQ-013 Latency SHALL be WAIT+2 cycles from the IDLE cycle that samples req to the ready cycle. No new grant SHALL be made in DONE.
REQ-014 cpu_in and dma_in SHALL hold their last captured value until their own next read completes; writes SHALL leave them unchanged.
REQ-015 Arbitration SHALL be round-robin:
- when both masters request in IDLE, grant the master not granted last;
- a single requester is always granted;
- the last-grant pointer resets to DMA, so the CPU wins the first contention.
REQ-016 mem_address and mem_d SHALL come from the latched registers, stable for all of ACCESS, and SHALL hold their values in IDLE.
REQ-017 Masters SHALL hold req/address/data until ready. A req dropped mid-access SHALL NOT abort the access; the ready pulse is still issued.
REQ-018 unmapped SHALL set on the first ACCESS cycle of an unmapped access and stay set until reset.
REQ-019 Unmapped accesses SHALL complete with WAIT treated as 0.
REQ-020 Arithmetic rules:
- the wait counter is 4 bits and SHALL NOT wrap;
- WAIT=15 gives 16 ACCESS cycles.

Reset
REQ-021 reset_n low SHALL act immediately without a clock. It SHALL force:
- state=IDLE, mem_we=0, cpu_ready=0, dma_ready=0;
- cpu_in=dma_in=0, mem_address=0, mem_d=0, unmapped=0;
- last-grant=DMA, wait counter=0.
REQ-022 Reset asserted mid-ACCESS SHALL abort the access with no further mem_we and no ready pulse. The first req after release SHALL be sampled on the first rising edge with reset_n high.

Verification
REQ-023 Bench SHALL cover:
- CPU write 0x12345←0x5A, then read with mem_q[0]=0x5A -> mem_we=0001 for exactly 1 cycle; cpu_ready 2 cycles after req; cpu_in=0x5A.
- CPU read 0xA0010 (WAIT=1), mem_q[1]=0x3C -> ACCESS 2 cycles; cpu_ready 3 cycles after req; cpu_in=0x3C; mem_we=0.
- CPU read 0xC0000 (unmapped) -> cpu_in=0xFF; mem_we stays 0; unmapped=1 and remains 1 after the following mapped accesses.
- cpu_req and dma_req high together, repeatedly after reset -> grants CPU, DMA, CPU, DMA; each ready pulses once per own access; dma_in is untouched by CPU reads.
- Read of 0xFE000 with mem_q[2]=0xEA while 0xFE000 also matches a test region 3 (BASE FE000, MASK F0000, REG_EN=1111) -> region 2 is selected, cpu_in=0xEA.
- reset_n pulsed low during ACCESS of a WAIT=1 write -> no ready; all outputs zero asynchronously; a retried write completes normally.

Source files
------------

// File: rtl/bus_router.sv
// rtl/bus_router.sv - two-master round-robin bus router with region decode and wait states
module bus_router #(
    parameter int AW = 20,
    parameter int DW = 8,
    parameter int NREG = 4,
    parameter logic [NREG*AW-1:0] BASE = {20'hFE000, 20'hA0000, 20'h00000, 20'h00000},
    parameter logic [NREG*AW-1:0] MASK = {20'hFE000, 20'hFC000, 20'hC0000, 20'h00000},
    parameter logic [NREG-1:0] REG_EN = 4'b0111,
    parameter logic [NREG*4-1:0] WAIT = {4'd0, 4'd1, 4'd0, 4'd0},
    parameter logic [DW-1:0] OPEN_BUS = 8'hFF
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [AW-1:0]      cpu_address,
    input  logic [DW-1:0]      cpu_out,
    output logic [DW-1:0]      cpu_in,
    output logic               cpu_ready,
    input  logic               dma_req,
    input  logic               dma_we,
    input  logic [AW-1:0]      dma_address,
    input  logic [DW-1:0]      dma_out,
    output logic [DW-1:0]      dma_in,
    output logic               dma_ready,
    output logic [AW-1:0]      mem_address,
    output logic [DW-1:0]      mem_d,
    output logic [NREG-1:0]    mem_we,
    input  logic [NREG*DW-1:0] mem_q,
    output logic               unmapped
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          last_dma;
    logic          grant_dma;
    logic          we_q;
    logic          hit_q;
    logic          first_q;
    logic [2:0]    region_q;
    logic [3:0]    cnt_q;

    logic          any_req;
    logic          gnt_dma_sel;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;
    logic          sel_we;
    logic          dec_hit;
    logic [2:0]    dec_region;
    logic [3:0]    dec_wait;
    logic [DW-1:0] rd_data;

    // Under contention the master that did not win last time gets the bus.
    always_comb begin
        any_req     = cpu_req | dma_req;
        gnt_dma_sel = dma_req & (~cpu_req | ~last_dma);
        sel_addr    = gnt_dma_sel ? dma_address : cpu_address;
        sel_data    = gnt_dma_sel ? dma_out : cpu_out;
        sel_we      = gnt_dma_sel ? dma_we : cpu_we;
    end

    // Scan from the top so the lowest matching region is the one left standing.
    always_comb begin
        dec_hit    = 1'b0;
        dec_region = '0;
        dec_wait   = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (REG_EN[i] &&
                ((sel_addr & MASK[i*AW +: AW]) == (BASE[i*AW +: AW] & MASK[i*AW +: AW]))) begin
                dec_hit    = 1'b1;
                dec_region = 3'(i);
                dec_wait   = WAIT[i*4 +: 4];
            end
        end
    end

    always_comb begin
        rd_data = OPEN_BUS;
        if (hit_q) begin
            for (int i = 0; i < NREG; i++) begin
                if (region_q == 3'(i)) begin
                    rd_data = mem_q[i*DW +: DW];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_we    = '0;
        cpu_ready = 1'b0;
        dma_ready = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (first_q && we_q && hit_q) begin
                    for (int i = 0; i < NREG; i++) begin
                        if (region_q == 3'(i)) begin
                            mem_we[i] = 1'b1;
                        end
                    end
                end
                if (cnt_q == 4'd0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                cpu_ready = ~grant_dma;
                dma_ready = grant_dma;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_dma    <= 1'b1;
            grant_dma   <= 1'b0;
            we_q        <= 1'b0;
            hit_q       <= 1'b0;
            first_q     <= 1'b0;
            region_q    <= '0;
            cnt_q       <= '0;
            mem_address <= '0;
            mem_d       <= '0;
            cpu_in      <= '0;
            dma_in      <= '0;
            unmapped    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_dma   <= gnt_dma_sel;
                        last_dma    <= gnt_dma_sel;
                        mem_address <= sel_addr;
                        mem_d       <= sel_data;
                        we_q        <= sel_we;
                        hit_q       <= dec_hit;
                        region_q    <= dec_region;
                        cnt_q       <= dec_hit ? dec_wait : 4'd0;
                        first_q     <= 1'b1;
                        if (!dec_hit) begin
                            unmapped <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    first_q <= 1'b0;
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else if (!we_q) begin
                        if (grant_dma) begin
                            dma_in <= rd_data;
                        end else begin
                            cpu_in <= rd_data;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_router.sv
// tb/tb_bus_router.sv - randomized self-checking bench for bus_router
`timescale 1ns/1ps
module tb_bus_router;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
    logic [19:0] cpu_address = '0, dma_address = '0;
    logic [7:0]  cpu_out = '0, dma_out = '0;
    logic [7:0]  cpu_in, dma_in;
    logic        cpu_ready, dma_ready, unmapped;
    logic [19:0] mem_address;
    logic [7:0]  mem_d;
    logic [3:0]  mem_we;
    logic [31:0] mem_q = '0;

    int total = 0;
    int bad = 0;

    // observed results of one transaction group
    int          r_clat, r_dlat, r_crdy, r_drdy, r_we_cnt;
    logic [3:0]  r_we_or;
    logic [19:0] r_we_addr;
    logic [7:0]  r_we_data;
    bit          r_to;

    // reference model state and expectations
    bit          m_last_dma;
    bit          m_unmapped;
    logic [7:0]  m_cpu_in, m_dma_in;
    int          e_clat, e_dlat, e_we_cnt;
    logic [3:0]  e_we_or;

    bus_router #(
        .AW(20), .DW(8), .NREG(4),
        .BASE({20'hFE000, 20'hFE000, 20'hA0000, 20'h00000}),
        .MASK({20'hF0000, 20'hFE000, 20'hFC000, 20'hC0000}),
        .REG_EN(4'b1111),
        .WAIT({4'd15, 4'd0, 4'd1, 4'd0}),
        .OPEN_BUS(8'hFF)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_address(cpu_address), .cpu_out(cpu_out),
        .cpu_in(cpu_in), .cpu_ready(cpu_ready),
        .dma_req(dma_req), .dma_we(dma_we), .dma_address(dma_address), .dma_out(dma_out),
        .dma_in(dma_in), .dma_ready(dma_ready),
        .mem_address(mem_address), .mem_d(mem_d), .mem_we(mem_we), .mem_q(mem_q),
        .unmapped(unmapped)
    );

    always #5 clock = ~clock;

    // Region map of this bench: r0 00000-3FFFF, r1 A0000-A3FFF (1 wait),
    // r2 FE000-FFFFF, r3 F0000-FFFFF (15 waits, shadowed by r2 at the top).
    function automatic int m_region(input logic [19:0] a);
        if ((a & 20'hC0000) == 20'h00000) return 0;
        if ((a & 20'hFC000) == 20'hA0000) return 1;
        if ((a & 20'hFE000) == 20'hFE000) return 2;
        if ((a & 20'hF0000) == 20'hF0000) return 3;
        return -1;
    endfunction

    function automatic int m_wait(input int r);
        if (r == 1) return 1;
        if (r == 3) return 15;
        return 0;
    endfunction

    function automatic logic [19:0] rand_addr();
        case ($urandom_range(0, 4))
            0: return {2'b00, 18'($urandom)};
            1: return 20'hA0000 | 20'($urandom_range(0, 16'h3FFF));
            2: return 20'hFE000 | 20'($urandom_range(0, 16'h1FFF));
            3: return 20'hF0000 | 20'($urandom_range(0, 16'hDFFF));
            default: return 20'hC0000 | 20'($urandom_range(0, 16'hFFFF));
        endcase
    endfunction

    task automatic model_reset();
        m_last_dma = 1'b1;
        m_unmapped = 1'b0;
        m_cpu_in   = 8'h00;
        m_dma_in   = 8'h00;
    endtask

    // Serve requesters in round-robin order; each takes wait+2 cycles plus one IDLE cycle between.
    task automatic predict(input bit creq, input bit cw, input logic [19:0] ca,
                           input bit dreq, input bit dw, input logic [19:0] da);
        bit first_dma, is_dma, wr;
        int t, r, lat;
        logic [19:0] a;
        e_clat = 0; e_dlat = 0; e_we_cnt = 0; e_we_or = '0;
        first_dma = dreq && (!creq || !m_last_dma);
        t = 0;
        for (int k = 0; k < 2; k++) begin
            is_dma = (k == 0) ? first_dma : !first_dma;
            if (is_dma ? dreq : creq) begin
                a = is_dma ? da : ca;
                wr = is_dma ? dw : cw;
                r = m_region(a);
                lat = t + m_wait(r) + 2;
                t = lat + 1;
                m_last_dma = is_dma;
                if (r < 0) m_unmapped = 1'b1;
                if (wr && r >= 0) begin
                    e_we_cnt++;
                    e_we_or[r] = 1'b1;
                end
                if (!wr) begin
                    if (is_dma) m_dma_in = (r < 0) ? 8'hFF : mem_q[r*8 +: 8];
                    else        m_cpu_in = (r < 0) ? 8'hFF : mem_q[r*8 +: 8];
                end
                if (is_dma) e_dlat = lat;
                else        e_clat = lat;
            end
        end
    endtask

    // Drive requests at a negedge in IDLE, hold each until its ready, then idle one cycle.
    task automatic run(input bit creq, input bit cw, input logic [19:0] ca, input logic [7:0] cd,
                       input bit dreq, input bit dw, input logic [19:0] da, input logic [7:0] dd);
        int n;
        bit cdone, ddone;
        r_clat = 0; r_dlat = 0; r_crdy = 0; r_drdy = 0; r_we_cnt = 0; r_we_or = '0;
        r_we_addr = '0; r_we_data = '0; r_to = 1'b0;
        cpu_req = creq; cpu_we = cw; cpu_address = ca; cpu_out = cd;
        dma_req = dreq; dma_we = dw; dma_address = da; dma_out = dd;
        cdone = !creq; ddone = !dreq; n = 0;
        while (!(cdone && ddone)) begin
            @(negedge clock);
            n++;
            if (mem_we != 4'b0) begin
                r_we_cnt++; r_we_or |= mem_we; r_we_addr = mem_address; r_we_data = mem_d;
            end
            if (cpu_ready) begin
                r_crdy++;
                if (!cdone) r_clat = n;
                cdone = 1'b1; cpu_req = 1'b0;
            end
            if (dma_ready) begin
                r_drdy++;
                if (!ddone) r_dlat = n;
                ddone = 1'b1; dma_req = 1'b0;
            end
            if (n >= 60) begin
                r_to = 1'b1;
                break;
            end
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        @(negedge clock);
        if (mem_we != 4'b0) r_we_cnt++;
        if (cpu_ready) r_crdy++;
        if (dma_ready) r_drdy++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        total++; if (mem_we !== 4'b0) begin bad++; $display("FAIL rst_mem_we got=%b want=0000", mem_we); end
        total++; if ({cpu_ready, dma_ready} !== 2'b00) begin bad++; $display("FAIL rst_ready got=%b want=00", {cpu_ready, dma_ready}); end
        total++; if ({cpu_in, dma_in} !== 16'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0000", {cpu_in, dma_in}); end
        total++; if ({mem_address, mem_d} !== 28'h0) begin bad++; $display("FAIL rst_mem_bus got=%h want=0", {mem_address, mem_d}); end
        total++; if (unmapped !== 1'b0) begin bad++; $display("FAIL rst_unmapped got=%b want=0", unmapped); end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        @(negedge clock);
    endtask

    task automatic test_write_read();
        mem_q = 32'h0;
        predict(1, 1, 20'h12345, 0, 0, 20'h0);
        run(1, 1, 20'h12345, 8'h5A, 0, 0, 20'h0, 8'h0);
        total++; if (r_to || r_clat != 2) begin bad++; $display("FAIL wr_latency got=%0d want=2", r_clat); end
        total++; if (r_we_cnt != 1 || r_we_or !== 4'b0001) begin bad++; $display("FAIL wr_mem_we got=%0d/%b want=1/0001", r_we_cnt, r_we_or); end
        total++; if (r_we_addr !== 20'h12345 || r_we_data !== 8'h5A) begin bad++; $display("FAIL wr_bus got=%h/%h want=12345/5a", r_we_addr, r_we_data); end
        total++; if (mem_address !== 20'h12345 || mem_d !== 8'h5A) begin bad++; $display("FAIL idle_hold got=%h/%h want=12345/5a", mem_address, mem_d); end
        total++; if (r_crdy != 1) begin bad++; $display("FAIL wr_ready_count got=%0d want=1", r_crdy); end
        mem_q[7:0] = 8'h5A;
        predict(1, 0, 20'h12345, 0, 0, 20'h0);
        run(1, 0, 20'h12345, 8'h00, 0, 0, 20'h0, 8'h0);
        total++; if (r_to || r_clat != 2) begin bad++; $display("FAIL rd_latency got=%0d want=2", r_clat); end
        total++; if (cpu_in !== 8'h5A) begin bad++; $display("FAIL rd_data got=%h want=5a", cpu_in); end
        total++; if (r_we_cnt != 0) begin bad++; $display("FAIL rd_mem_we got=%0d want=0", r_we_cnt); end
    endtask

    task automatic test_wait_read();
        mem_q[15:8] = 8'h3C;
        predict(1, 0, 20'hA0010, 0, 0, 20'h0);
        run(1, 0, 20'hA0010, 8'h00, 0, 0, 20'h0, 8'h0);
        total++; if (r_to || r_clat != 3) begin bad++; $display("FAIL wait_latency got=%0d want=3", r_clat); end
        total++; if (cpu_in !== 8'h3C) begin bad++; $display("FAIL wait_data got=%h want=3c", cpu_in); end
        total++; if (r_we_cnt != 0) begin bad++; $display("FAIL wait_mem_we got=%0d want=0", r_we_cnt); end
        predict(1, 0, 20'hF1234, 0, 0, 20'h0);
        run(1, 0, 20'hF1234, 8'h00, 0, 0, 20'h0, 8'h0);
        total++; if (r_to || r_clat != 17) begin bad++; $display("FAIL wait15_latency got=%0d want=17", r_clat); end
        total++; if (cpu_in !== mem_q[31:24]) begin bad++; $display("FAIL wait15_data got=%h want=%h", cpu_in, mem_q[31:24]); end
    endtask

    task automatic test_unmapped();
        predict(1, 0, 20'hC0000, 0, 0, 20'h0);
        run(1, 0, 20'hC0000, 8'h00, 0, 0, 20'h0, 8'h0);
        total++; if (r_to || r_clat != 2) begin bad++; $display("FAIL unm_latency got=%0d want=2", r_clat); end
        total++; if (cpu_in !== 8'hFF) begin bad++; $display("FAIL unm_data got=%h want=ff", cpu_in); end
        total++; if (unmapped !== 1'b1) begin bad++; $display("FAIL unm_flag got=%b want=1", unmapped); end
        predict(0, 0, 20'h0, 1, 1, 20'hC8000);
        run(0, 0, 20'h0, 8'h00, 1, 1, 20'hC8000, 8'h99);
        total++; if (r_we_cnt != 0 || r_dlat != 2) begin bad++; $display("FAIL unm_write got=%0d/%0d want=0/2", r_we_cnt, r_dlat); end
        predict(1, 1, 20'hA0004, 0, 0, 20'h0);
        run(1, 1, 20'hA0004, 8'h11, 0, 0, 20'h0, 8'h0);
        total++; if (unmapped !== 1'b1) begin bad++; $display("FAIL unm_sticky got=%b want=1", unmapped); end
    endtask

    task automatic test_priority();
        mem_q[23:16] = 8'hEA;
        mem_q[31:24] = 8'h17;
        predict(1, 0, 20'hFE000, 0, 0, 20'h0);
        run(1, 0, 20'hFE000, 8'h00, 0, 0, 20'h0, 8'h0);
        total++; if (cpu_in !== 8'hEA) begin bad++; $display("FAIL prio_data got=%h want=ea", cpu_in); end
        total++; if (r_to || r_clat != 2) begin bad++; $display("FAIL prio_latency got=%0d want=2", r_clat); end
    endtask

    task automatic test_arbitration();
        logic [19:0] ca, da;
        for (int k = 0; k < 4; k++) begin
            mem_q = $urandom;
            ca = rand_addr();
            da = rand_addr();
            predict(1, 0, ca, 1, 0, da);
            run(1, 0, ca, 8'h00, 1, 0, da, 8'h00);
            total++; if (r_to || r_clat != e_clat || r_dlat != e_dlat) begin bad++; $display("FAIL arb_order[%0d] got=%0d/%0d want=%0d/%0d", k, r_clat, r_dlat, e_clat, e_dlat); end
            total++; if (r_crdy != 1 || r_drdy != 1) begin bad++; $display("FAIL arb_ready[%0d] got=%0d/%0d want=1/1", k, r_crdy, r_drdy); end
            total++; if (cpu_in !== m_cpu_in || dma_in !== m_dma_in) begin bad++; $display("FAIL arb_data[%0d] got=%h/%h want=%h/%h", k, cpu_in, dma_in, m_cpu_in, m_dma_in); end
        end
        predict(1, 0, 20'h00100, 0, 0, 20'h0);
        run(1, 0, 20'h00100, 8'h00, 0, 0, 20'h0, 8'h0);
        total++; if (dma_in !== m_dma_in) begin bad++; $display("FAIL dma_untouched got=%h want=%h", dma_in, m_dma_in); end
        predict(1, 0, 20'h00200, 1, 0, 20'h00300);
        run(1, 0, 20'h00200, 8'h00, 1, 0, 20'h00300, 8'h00);
        total++; if (r_dlat != 2 || r_clat != 5) begin bad++; $display("FAIL arb_dma_first got=%0d/%0d want=5/2", r_clat, r_dlat); end
    endtask

    task automatic test_random();
        bit creq, dreq, cw, dw;
        logic [19:0] ca, da;
        logic [7:0] cd, dd;
        for (int k = 0; k < 30; k++) begin
            mem_q = $urandom;
            creq = 1'($urandom_range(0, 1));
            dreq = creq ? 1'($urandom_range(0, 1)) : 1'b1;
            cw = 1'($urandom_range(0, 1));
            dw = 1'($urandom_range(0, 1));
            ca = rand_addr(); da = rand_addr();
            cd = 8'($urandom); dd = 8'($urandom);
            predict(creq, cw, ca, dreq, dw, da);
            run(creq, cw, ca, cd, dreq, dw, da, dd);
            total++; if (r_to || r_clat != e_clat || r_dlat != e_dlat) begin bad++; $display("FAIL rnd_latency[%0d] got=%0d/%0d want=%0d/%0d", k, r_clat, r_dlat, e_clat, e_dlat); end
            total++; if (r_crdy != int'(creq) || r_drdy != int'(dreq)) begin bad++; $display("FAIL rnd_ready[%0d] got=%0d/%0d want=%0d/%0d", k, r_crdy, r_drdy, creq, dreq); end
            total++; if (r_we_cnt != e_we_cnt || r_we_or !== e_we_or) begin bad++; $display("FAIL rnd_mem_we[%0d] got=%0d/%b want=%0d/%b", k, r_we_cnt, r_we_or, e_we_cnt, e_we_or); end
            total++; if (cpu_in !== m_cpu_in || dma_in !== m_dma_in) begin bad++; $display("FAIL rnd_data[%0d] got=%h/%h want=%h/%h", k, cpu_in, dma_in, m_cpu_in, m_dma_in); end
            total++; if (unmapped !== m_unmapped) begin bad++; $display("FAIL rnd_unmapped[%0d] got=%b want=%b", k, unmapped, m_unmapped); end
        end
    endtask

    task automatic test_reset_mid();
        bit seen_ready;
        seen_ready = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_address = 20'hA0010; cpu_out = 8'h77;
        @(negedge clock);
        total++; if (mem_we !== 4'b0010) begin bad++; $display("FAIL mid_first_we got=%b want=0010", mem_we); end
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (mem_we !== 4'b0 || cpu_ready !== 1'b0 || dma_ready !== 1'b0) begin bad++; $display("FAIL mid_async_ctl got=%b/%b/%b want=0", mem_we, cpu_ready, dma_ready); end
        total++; if ({mem_address, mem_d, cpu_in, dma_in, unmapped} !== 45'h0) begin bad++; $display("FAIL mid_async_data got=%h want=0", {mem_address, mem_d, cpu_in, dma_in, unmapped}); end
        cpu_req = 1'b0;
        repeat (2) begin
            @(negedge clock);
            if (cpu_ready || dma_ready || mem_we != 4'b0) seen_ready = 1'b1;
        end
        reset_n = 1'b1;
        model_reset();
        repeat (3) begin
            @(negedge clock);
            if (cpu_ready || dma_ready || mem_we != 4'b0) seen_ready = 1'b1;
        end
        total++; if (seen_ready) begin bad++; $display("FAIL mid_no_ready got=1 want=0"); end
        predict(1, 1, 20'hA0010, 0, 0, 20'h0);
        run(1, 1, 20'hA0010, 8'h77, 0, 0, 20'h0, 8'h0);
        total++; if (r_to || r_clat != 3 || r_crdy != 1) begin bad++; $display("FAIL retry_latency got=%0d/%0d want=3/1", r_clat, r_crdy); end
        total++; if (r_we_cnt != 1 || r_we_or !== 4'b0010 || r_we_data !== 8'h77) begin bad++; $display("FAIL retry_we got=%0d/%b/%h want=1/0010/77", r_we_cnt, r_we_or, r_we_data); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wait_read();
        test_unmapped();
        test_priority();
        test_arbitration();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
